equiv_sequencer: RTL and testbench



---
 rtl/equiv_sequencer.sv | 139 +++++++++++++
 tb/tb_equiv_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_sequencer.sv
// Equivalence-run sequencer: drives LFSR stimulus to two units, waits a settle time,
// compares their outputs and records the mismatch count and first failing vector.
module equiv_sequencer #(
    parameter int          IN_W        = 4,
    parameter int          OUT_W       = 2,
    parameter int          NUM_VECTORS = 20,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    output logic [IN_W-1:0]                    vec_out,
    input  logic [OUT_W-1:0]                   out_s,
    input  logic [OUT_W-1:0]                   out_b,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   mismatch_count,
    output logic                               first_fail_valid,
    output logic [IN_W-1:0]                    first_fail_vec
);

    localparam int          MW       = $clog2(NUM_VECTORS + 1);
    localparam int          IW       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int          SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr;
    logic [IW-1:0]   vec_idx;
    logic [SW-1:0]   settle_cnt;
    logic            last_vec;
    logic            settle_end;
    logic            mismatch;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign last_vec   = (vec_idx == IW'(NUM_VECTORS - 1));
    assign settle_end = (settle_cnt == SW'(SETTLE - 1));
    assign mismatch   = (out_s != out_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_APPLY;
            S_APPLY: begin
                if (abort)           state_nxt = S_IDLE;
                else if (SETTLE > 0) state_nxt = S_WAIT;
                else                 state_nxt = S_COMPARE;
            end
            S_WAIT: begin
                if (abort)           state_nxt = S_IDLE;
                else if (settle_end) state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (abort)         state_nxt = S_IDLE;
                else if (last_vec) state_nxt = S_DONE;
                else               state_nxt = S_APPLY;
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_COMPARE);
        done = (state == S_DONE);
    end

    // vec_out is loaded on the edge that enters APPLY; the LFSR steps on that same edge,
    // so vector 0 is the seed itself and vector k is the k-th successor state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr             <= SEED_EFF;
            vec_out          <= '0;
            vec_idx          <= '0;
            settle_cnt       <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr             <= lfsr_step(SEED_EFF);
                        vec_out          <= SEED_EFF[IN_W-1:0];
                        vec_idx          <= '0;
                        settle_cnt       <= '0;
                        mismatch_count   <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        pass             <= 1'b0;
                    end
                end
                S_APPLY: settle_cnt <= '0;
                S_WAIT: begin
                    if (!abort) settle_cnt <= settle_cnt + 1'b1;
                end
                S_COMPARE: begin
                    if (!abort) begin
                        if (mismatch) begin
                            mismatch_count <= mismatch_count + MW'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec_out;
                            end
                        end
                        vec_idx <= vec_idx + 1'b1;
                        if (!last_vec) begin
                            vec_out <= lfsr[IN_W-1:0];
                            lfsr    <= lfsr_step(lfsr);
                        end
                    end
                end
                S_DONE: pass <= (mismatch_count == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_sequencer.sv
// Self-checking bench for equiv_sequencer: default instance checked against an LFSR/unit
// reference model; a second SETTLE=0, NUM_VECTORS=1 instance checks minimal timing.
module tb_equiv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [3:0] vec_out;
    logic [1:0] out_s, out_b;
    logic       busy, done, pass, first_fail_valid;
    logic [4:0] mismatch_count;
    logic [3:0] first_fail_vec;

    logic       start1, abort1, force1;
    logic [3:0] vec1;
    logic [1:0] out_s1, out_b1;
    logic       busy1, done1, pass1, ffv1;
    logic [0:0] cnt1;
    logic [3:0] ffvec1;

    int          mode;
    logic [15:0] bad_mask;
    logic [3:0]  exp_vec [20];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    equiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_out),
        .out_s(out_s), .out_b(out_b), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mismatch_count), .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec)
    );

    equiv_sequencer #(.IN_W(4), .OUT_W(2), .NUM_VECTORS(1), .SETTLE(0), .SEED(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec_out(vec1),
        .out_s(out_s1), .out_b(out_b1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(cnt1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    // Units under test: structural = low bits of the vector, behavioural = same with optional fault.
    always_comb begin
        out_s = vec_out[1:0];
        case (mode)
            1:       out_b = out_s ^ 2'b01;
            2:       out_b = out_s ^ {1'b0, (vec_out == 4'h5)};
            3:       out_b = out_s ^ {1'b0, bad_mask[vec_out]};
            default: out_b = out_s;
        endcase
        out_s1 = vec1[1:0];
        out_b1 = out_s1 ^ {1'b0, force1};
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [3:0] v);
        case (mode)
            1:       return 1'b1;
            2:       return v == 4'h5;
            3:       return bad_mask[v];
            default: return 1'b0;
        endcase
    endfunction

    // Expected results after the first nv vectors of a run.
    task automatic ref_run(input int nv, output int cnt, output bit ffv, output logic [3:0] ffvec);
        cnt = 0; ffv = 0; ffvec = '0;
        for (int k = 0; k < nv; k++) begin
            if (ref_bad(exp_vec[k])) begin
                if (!ffv) begin ffv = 1; ffvec = exp_vec[k]; end
                cnt++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_vec"}, vec_out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_cnt"}, mismatch_count, 0);
        check_eq({tag, "_ffv"}, first_fail_valid, 0);
        check_eq({tag, "_ffvec"}, first_fail_vec, 0);
    endtask

    // Called while idle, #1 after an edge; start is sampled at the end of this cycle (cycle 0).
    task automatic run0(input int abort_cyc, input bit start_in_done);
        int c, done_cyc, cnt, nv;
        bit ffv;
        logic [3:0] ffvec;
        done_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 1; c < 200; c++) begin
            if (abort_cyc > 0 && c == abort_cyc + 1) break;
            if ((c - 1) % 3 == 0 && (c - 1) / 3 < 20)
                check_eq($sformatf("vec%0d", (c - 1) / 3), vec_out, exp_vec[(c - 1) / 3]);
            if (done) begin done_cyc = c; break; end
            abort = (c == abort_cyc);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        if (abort_cyc > 0) begin
            nv = (abort_cyc - 1) / 3;
            ref_run(nv, cnt, ffv, ffvec);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_pass", pass, 0);
            check_eq("abort_cnt", mismatch_count, cnt);
            check_eq("abort_ffv", first_fail_valid, ffv);
        end else begin
            check_eq("done_cycle", done_cyc, 61);
            check_eq("busy_in_done", busy, 0);
            start = start_in_done;
            @(posedge clk); #1;
            start = 1'b0;
            ref_run(20, cnt, ffv, ffvec);
            check_eq("pass", pass, cnt == 0);
            check_eq("cnt", mismatch_count, cnt);
            check_eq("ffv", first_fail_valid, ffv);
            if (ffv) check_eq("ffvec", first_fail_vec, ffvec);
            check_eq("idle_done", done, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_vec_hold", vec_out, exp_vec[19]);
        end
    endtask

    initial begin
        logic [15:0] v;
        v = 16'hACE1;
        for (int k = 0; k < 20; k++) begin
            exp_vec[k] = v[3:0];
            v = {v[14:0], ^(v & 16'hB400)};
        end
        mode = 0; bad_mask = '0; force1 = 1'b0;
        start = 0; abort = 0; start1 = 0; abort1 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check_eq("rst1_busy", busy1, 0);
        check_eq("rst1_cnt", cnt1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        mode = 0; run0(-1, 1'b0);
        mode = 1; run0(-1, 1'b1);
        check_eq("xor_ffvec_first", first_fail_vec, exp_vec[0]);
        mode = 2;
        for (int r = 0; r < 2; r++) begin
            run0(-1, 1'b0);
            if (first_fail_valid) check_eq("v5_ffvec", first_fail_vec, 5);
        end

        mode = 1; run0(11, 1'b0);
        mode = 0; run0(-1, 1'b0);

        mode = 3;
        for (int r = 0; r < 4; r++) begin
            bad_mask = 16'($urandom);
            run0(-1, 1'b0);
        end
        bad_mask = 16'($urandom);
        run0(int'($urandom_range(1, 60)), 1'b0);

        // Asynchronous reset in the middle of vector 10.
        bad_mask = 16'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run0(-1, 1'b0);

        // Minimal instance: start pulses in APPLY and DONE cycles are ignored.
        force1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        check_eq("m_busy_c1", busy1, 1);
        check_eq("m_vec_c1", vec1, exp_vec[0]);
        @(posedge clk); #1;
        start1 = 1'b0;
        check_eq("m_busy_c2", busy1, 1);
        check_eq("m_done_c2", done1, 0);
        @(posedge clk); #1;
        check_eq("m_done_c3", done1, 1);
        check_eq("m_busy_c3", busy1, 0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check_eq("m_busy_c4", busy1, 0);
        check_eq("m_pass_c4", pass1, 0);
        check_eq("m_cnt_c4", cnt1, 1);
        check_eq("m_ffvec_c4", ffvec1, exp_vec[0]);
        force1 = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check_eq("m_busy_restart", busy1, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("m_done_rerun", done1, 1);
        @(posedge clk); #1;
        check_eq("m_pass_rerun", pass1, 1);
        check_eq("m_cnt_rerun", cnt1, 0);
        check_eq("m_ffv_rerun", ffv1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
